display_7seg_ctrl: RTL and testbench

Memory-mapped controller that owns the configuration of the four-digit 7-segment display driver. It sits between the RISC-V data bus and `display_7seg`, holding the digit values and the digit/dot enables in bus-accessible registers. It adds two autonomous features: per-digit blink masking and a free-running hexadecimal counter mode that increments the displayed value at a programmable rate.

---
 rtl/display_7seg_ctrl.sv | 120 ++++++++++++
 tb/tb_display_7seg_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/display_7seg_ctrl.sv
// Bus-mapped register block for the four-digit 7-segment driver, adding per-digit
// blink masking and a free-running hexadecimal counter mode.
module display_7seg_ctrl #(
   parameter int unsigned BLINK_BITS = 24
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sel,
   input  logic        we,
   input  logic [1:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic [3:0]  num0,
   output logic [3:0]  num1,
   output logic [3:0]  num2,
   output logic [3:0]  num3,
   output logic [3:0]  nums_enable,
   output logic [3:0]  dots_enable
);

   logic [15:0]           data_q, data_d;
   logic [7:0]            en_q, en_d;
   logic [3:0]            blink_q, blink_d;
   logic                  count_en_q, count_en_d;
   logic [23:0]           prescale_q, prescale_d;
   logic [23:0]           pre_cnt_q, pre_cnt_d;
   logic [BLINK_BITS-1:0] blink_cnt_q, blink_cnt_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  ready_q, ready_d;
   logic                  accept;
   logic [31:0]           rd_mux;
   logic                  phase_off;

   // A cycle with ready high never accepts, giving one transfer per two cycles.
   assign accept = sel & ~ready_q;

   always_comb begin
      rd_mux = '0;
      unique case (addr)
         2'd0: rd_mux = {16'd0, data_q};
         2'd1: rd_mux = {24'd0, en_q};
         2'd2: rd_mux = {28'd0, blink_q};
         2'd3: rd_mux = {prescale_q, 7'd0, count_en_q};
      endcase
   end

   always_comb begin
      data_d      = data_q;
      en_d        = en_q;
      blink_d     = blink_q;
      count_en_d  = count_en_q;
      prescale_d  = prescale_q;
      pre_cnt_d   = '0;
      blink_cnt_d = blink_cnt_q + BLINK_BITS'(1);
      rdata_d     = rdata_q;
      ready_d     = accept;

      if (count_en_q) begin
         if (pre_cnt_q == prescale_q) begin
            data_d = data_q + 16'd1;
         end else begin
            pre_cnt_d = pre_cnt_q + 24'd1;
         end
      end

      // Bus writes are applied last so they override a same-edge increment.
      if (accept) begin
         if (we) begin
            unique case (addr)
               2'd0: data_d  = wdata[15:0];
               2'd1: en_d    = wdata[7:0];
               2'd2: blink_d = wdata[3:0];
               2'd3: begin
                  count_en_d = wdata[0];
                  prescale_d = wdata[31:8];
                  pre_cnt_d  = '0;
               end
            endcase
         end else begin
            rdata_d = rd_mux;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q      <= '0;
         en_q        <= 8'h0F;
         blink_q     <= '0;
         count_en_q  <= 1'b0;
         prescale_q  <= '0;
         pre_cnt_q   <= '0;
         blink_cnt_q <= '0;
         rdata_q     <= '0;
         ready_q     <= 1'b0;
      end else begin
         data_q      <= data_d;
         en_q        <= en_d;
         blink_q     <= blink_d;
         count_en_q  <= count_en_d;
         prescale_q  <= prescale_d;
         pre_cnt_q   <= pre_cnt_d;
         blink_cnt_q <= blink_cnt_d;
         rdata_q     <= rdata_d;
         ready_q     <= ready_d;
      end
   end

   assign phase_off   = blink_cnt_q[BLINK_BITS-1];
   assign rdata       = rdata_q;
   assign ready       = ready_q;
   assign num0        = data_q[3:0];
   assign num1        = data_q[7:4];
   assign num2        = data_q[11:8];
   assign num3        = data_q[15:12];
   assign nums_enable = en_q[3:0] & ~(blink_q & {4{phase_off}});
   assign dots_enable = en_q[7:4];

endmodule

// File: tb/tb_display_7seg_ctrl.sv
// Directed bench for display_7seg_ctrl: read data checked through an expected-value
// queue, display outputs checked against constants and a blink phase counter.
module tb_display_7seg_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sel = 1'b0;
   logic        we = 1'b0;
   logic [1:0]  addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        ready;
   logic [3:0]  num0, num1, num2, num3;
   logic [3:0]  nums_enable, dots_enable;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_q[$];
   logic [3:0]  tcnt;

   display_7seg_ctrl #(.BLINK_BITS(4)) dut (
      .clk(clk), .rst_n(rst_n), .sel(sel), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata), .ready(ready), .num0(num0), .num1(num1), .num2(num2), .num3(num3),
      .nums_enable(nums_enable), .dots_enable(dots_enable)
   );

   always #5 clk = ~clk;

   // Cycles since reset release; bit 3 is the blink off-phase for BLINK_BITS=4.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tcnt <= '0;
      else        tcnt <= tcnt + 4'd1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pop_cmp(input string tag);
      if (exp_q.size() == 0) chk({tag, "_queue_empty"}, 32'd1, 32'd0);
      else chk(tag, rdata, exp_q.pop_front());
   endtask

   // One transfer; returns on the falling edge where ready is high, with sel dropped.
   task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input string tag);
      int n;
      if (!w) exp_q.push_back(exp_rd);
      @(negedge clk);
      sel = 1'b1; we = w; addr = a; wdata = d;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ready && n < 10);
      sel = 1'b0; we = 1'b0;
      chk({tag, "_ready"}, ready, 1);
      if (ready && !w) pop_cmp(tag);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_nums"}, {num3, num2, num1, num0}, 16'h0000);
      chk({tag, "_nums_en"}, nums_enable, 4'hF);
      chk({tag, "_dots_en"}, dots_enable, 4'h0);
   endtask

   initial begin
      logic [5:0] pattern;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_ready", ready, 0);
      chk("rst_rdata", rdata, 0);
      chk_reset_outputs("rst");
      rst_n = 1'b1;
      bus(1'b0, 2'd0, 0, 32'h0000_0000, "rst_data");
      bus(1'b0, 2'd1, 0, 32'h0000_000F, "rst_enable");
      bus(1'b0, 2'd2, 0, 32'h0000_0000, "rst_blink");
      bus(1'b0, 2'd3, 0, 32'h0000_0000, "rst_ctrl");

      // Write/readback with reserved bits dropped
      bus(1'b1, 2'd0, 32'hDEAD_BEEF, 0, "wr_data");
      chk("wr_nums_at_ready", {num3, num2, num1, num0}, 16'hBEEF);
      @(negedge clk);
      chk("ready_one_cycle", ready, 0);
      bus(1'b0, 2'd0, 0, 32'h0000_BEEF, "rd_data");

      // Held sel: ready pulses every other cycle
      @(negedge clk);
      sel = 1'b1; we = 1'b0; addr = 2'd0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         pattern[5-i] = ready;
         if (ready) begin
            exp_q.push_back(32'h0000_BEEF);
            pop_cmp("held_rd");
         end
      end
      sel = 1'b0;
      chk("held_pattern", pattern, 6'b101010);

      // Blink: digits 0 and 2 masked in the off phase, dots untouched
      bus(1'b1, 2'd1, 32'h0000_00AF, 0, "wr_enable");
      bus(1'b1, 2'd2, 32'h0000_0005, 0, "wr_blink");
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         chk("blink_nums_en", nums_enable, tcnt[3] ? 4'hA : 4'hF);
         chk("blink_dots_en", dots_enable, 4'hA);
      end
      bus(1'b1, 2'd2, 32'h0, 0, "wr_blink_off");

      // Counter wrap with PRESCALE=2: period 3 cycles
      bus(1'b1, 2'd0, 32'h0000_FFFE, 0, "wr_fffe");
      bus(1'b1, 2'd3, (32'd2 << 8) | 32'd1, 0, "wr_ctrl_cnt");
      chk("cnt_start", {num3, num2, num1, num0}, 16'hFFFE);
      repeat (2) @(negedge clk);
      chk("cnt_before_inc", {num3, num2, num1, num0}, 16'hFFFE);
      @(negedge clk);
      chk("cnt_ffff", {num3, num2, num1, num0}, 16'hFFFF);
      repeat (2) @(negedge clk);
      chk("cnt_before_wrap", {num3, num2, num1, num0}, 16'hFFFF);
      @(negedge clk);
      chk("cnt_wrap", {num3, num2, num1, num0}, 16'h0000);

      // PRESCALE=0: bus write beats the same-edge increment
      bus(1'b1, 2'd3, 32'h0000_0001, 0, "wr_ctrl_fast");
      bus(1'b1, 2'd0, 32'h0000_1234, 0, "wr_collide");
      chk("collide_win", {num3, num2, num1, num0}, 16'h1234);
      @(negedge clk);
      chk("collide_next", {num3, num2, num1, num0}, 16'h1235);

      // count_en=0 freezes DATA
      bus(1'b1, 2'd3, 32'h0000_0000, 0, "wr_ctrl_stop");
      bus(1'b1, 2'd0, 32'h0000_0042, 0, "wr_0042");
      repeat (5) @(negedge clk);
      chk("cnt_frozen", {num3, num2, num1, num0}, 16'h0042);
      bus(1'b0, 2'd3, 0, 32'h0000_0000, "rd_ctrl_stop");

      // Reset asserted the cycle after a write is accepted
      @(negedge clk);
      sel = 1'b1; we = 1'b1; addr = 2'd1; wdata = 32'h0000_0033;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      sel = 1'b0; we = 1'b0;
      @(negedge clk);
      chk("midrst_ready", ready, 0);
      chk("midrst_rdata", rdata, 0);
      chk_reset_outputs("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      bus(1'b0, 2'd0, 0, 32'h0000_0000, "midrst_data");
      bus(1'b0, 2'd1, 0, 32'h0000_000F, "midrst_enable");
      bus(1'b0, 2'd2, 0, 32'h0000_0000, "midrst_blink");
      bus(1'b0, 2'd3, 0, 32'h0000_0000, "midrst_ctrl");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
